// File: rtl/tri_chk_pkg.sv
// Shared types for the triangle-sequence checker: FSM state encoding and direction constants.
package tri_chk_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } tri_state_t;

    localparam logic UP   = 1'b0;
    localparam logic DOWN = 1'b1;

endpackage

// File: rtl/tri_next_expect.sv
// Predicts the next triangle value from prev and direction, flagging a turnaround step.
module tri_next_expect
    import tri_chk_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MAX_VAL = 15
) (
    input  logic [WIDTH-1:0] i_prev,
    input  logic             i_dir_down,
    output logic [WIDTH-1:0] o_expect,
    output logic             o_flip,
    output logic             o_prev_ok
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

    // Endpoints reflect instead of wrapping, so +1/-1 is never taken at MAX_VAL/0.
    always_comb begin
        o_expect  = '0;
        o_flip    = 1'b0;
        o_prev_ok = (i_prev <= MAXV);
        if (i_dir_down == UP) begin
            if (i_prev == MAXV) begin
                o_expect = MAXV - WIDTH'(1);
                o_flip   = 1'b1;
            end else begin
                o_expect = i_prev + WIDTH'(1);
            end
        end else begin
            if (i_prev == '0) begin
                o_expect = WIDTH'(1);
                o_flip   = 1'b1;
            end else begin
                o_expect = i_prev - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/tri_seq_checker.sv
// Receive-side checker for a 0..MAX_VAL..0 triangle counter stream: hunts, locks, flags errors.
// Optional valley-to-valley period measurement enabled by defining TRI_CHECK_PERIOD_EN.
module tri_seq_checker
    import tri_chk_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_VAL  = 15,
    parameter int unsigned SYNC_LEN = 2,
    parameter int unsigned ERR_W    = 8,
    parameter int unsigned PER_W    = 6
) (
    input  logic             CP,
    input  logic             CLEAR,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    output logic             locked,
    output logic             dir_down,
    output logic             peak,
    output logic             valley,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
    output logic             period_done,
    output logic [PER_W-1:0] period_len
);

    localparam int unsigned      MW   = $clog2(SYNC_LEN + 1);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

    tri_state_t       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_prev, w_prev_nxt;
    logic [MW-1:0]    r_match, w_match_nxt;
    logic             r_step_dn, w_step_dn_nxt;
    logic             r_locked, w_locked_nxt;
    logic             r_dir_down, w_dir_nxt;
    logic             r_peak, w_peak_nxt;
    logic             r_valley, w_valley_nxt;
    logic             r_err, w_err_nxt;
    logic [ERR_W-1:0] r_err_cnt, w_err_cnt_nxt;

    logic [WIDTH-1:0] w_up_exp, w_dn_exp, w_lock_exp;
    logic             w_up_flip, w_dn_flip, w_lock_flip;
    logic             w_up_ok, w_dn_ok;
    logic             w_step_up, w_step_dn, w_lock_hit;

    tri_next_expect #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) u_exp_up (
        .i_prev     (r_prev),
        .i_dir_down (UP),
        .o_expect   (w_up_exp),
        .o_flip     (w_up_flip),
        .o_prev_ok  (w_up_ok)
    );

    tri_next_expect #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) u_exp_dn (
        .i_prev     (r_prev),
        .i_dir_down (DOWN),
        .o_expect   (w_dn_exp),
        .o_flip     (w_dn_flip),
        .o_prev_ok  (w_dn_ok)
    );

    // A reflected prediction is not a plain step, so it never counts toward sync.
    assign w_step_up   = w_up_ok && !w_up_flip && (sample == w_up_exp);
    assign w_step_dn   = w_dn_ok && !w_dn_flip && (sample == w_dn_exp);
    assign w_lock_exp  = r_dir_down ? w_dn_exp  : w_up_exp;
    assign w_lock_flip = r_dir_down ? w_dn_flip : w_up_flip;
    assign w_lock_hit  = (sample == w_lock_exp);

    always_comb begin
        w_state_nxt   = r_state;
        w_prev_nxt    = r_prev;
        w_match_nxt   = r_match;
        w_step_dn_nxt = r_step_dn;
        w_locked_nxt  = r_locked;
        w_dir_nxt     = r_dir_down;
        w_peak_nxt    = 1'b0;
        w_valley_nxt  = 1'b0;
        w_err_nxt     = 1'b0;
        w_err_cnt_nxt = r_err_cnt;
        if (sample_valid) begin
            w_prev_nxt = sample;
            unique case (r_state)
                HUNT: begin
                    w_match_nxt = '0;
                    w_state_nxt = SYNC;
                end
                SYNC: begin
                    if (w_step_up || w_step_dn) begin
                        if ((r_match != '0) && (r_step_dn == w_step_dn)) begin
                            w_match_nxt = r_match + MW'(1);
                        end else begin
                            w_match_nxt = MW'(1);
                        end
                        w_step_dn_nxt = w_step_dn;
                        if (w_match_nxt == MW'(SYNC_LEN)) begin
                            w_state_nxt  = LOCK;
                            w_locked_nxt = 1'b1;
                            w_dir_nxt    = w_step_dn;
                        end
                    end else begin
                        w_match_nxt = '0;
                    end
                end
                LOCK: begin
                    if (w_lock_hit) begin
                        if (w_lock_flip) begin
                            w_dir_nxt = ~r_dir_down;
                        end
                        w_peak_nxt   = (sample == MAXV);
                        w_valley_nxt = (sample == '0);
                    end else begin
                        w_err_nxt     = 1'b1;
                        w_err_cnt_nxt = (r_err_cnt == '1) ? r_err_cnt : r_err_cnt + ERR_W'(1);
                        w_locked_nxt  = 1'b0;
                        w_dir_nxt     = 1'b0;
                        w_match_nxt   = '0;
                        w_state_nxt   = SYNC;
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge CP or posedge CLEAR) begin
        if (CLEAR) begin
            r_state    <= HUNT;
            r_prev     <= '0;
            r_match    <= '0;
            r_step_dn  <= 1'b0;
            r_locked   <= 1'b0;
            r_dir_down <= 1'b0;
            r_peak     <= 1'b0;
            r_valley   <= 1'b0;
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_prev     <= w_prev_nxt;
            r_match    <= w_match_nxt;
            r_step_dn  <= w_step_dn_nxt;
            r_locked   <= w_locked_nxt;
            r_dir_down <= w_dir_nxt;
            r_peak     <= w_peak_nxt;
            r_valley   <= w_valley_nxt;
            r_err      <= w_err_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
        end
    end

    assign locked    = r_locked;
    assign dir_down  = r_dir_down;
    assign peak      = r_peak;
    assign valley    = r_valley;
    assign err       = r_err;
    assign err_count = r_err_cnt;

`ifdef TRI_CHECK_PERIOD_EN
    logic [PER_W-1:0] r_per_cnt, w_per_cnt_nxt;
    logic [PER_W-1:0] r_per_len, w_per_len_nxt;
    logic             r_seen, w_seen_nxt;
    logic             r_pdone, w_pdone_nxt;

    // The valley sample itself opens the next period, hence the restart at 1.
    always_comb begin
        w_per_cnt_nxt = r_per_cnt;
        w_per_len_nxt = r_per_len;
        w_seen_nxt    = r_seen;
        w_pdone_nxt   = 1'b0;
        if (sample_valid && (r_state == LOCK)) begin
            if (!w_lock_hit) begin
                w_per_cnt_nxt = '0;
                w_seen_nxt    = 1'b0;
            end else if (sample == '0) begin
                if (r_seen) begin
                    w_pdone_nxt   = 1'b1;
                    w_per_len_nxt = r_per_cnt;
                end
                w_per_cnt_nxt = PER_W'(1);
                w_seen_nxt    = 1'b1;
            end else begin
                w_per_cnt_nxt = (r_per_cnt == '1) ? r_per_cnt : r_per_cnt + PER_W'(1);
            end
        end
    end

    always_ff @(posedge CP or posedge CLEAR) begin
        if (CLEAR) begin
            r_per_cnt <= '0;
            r_per_len <= '0;
            r_seen    <= 1'b0;
            r_pdone   <= 1'b0;
        end else begin
            r_per_cnt <= w_per_cnt_nxt;
            r_per_len <= w_per_len_nxt;
            r_seen    <= w_seen_nxt;
            r_pdone   <= w_pdone_nxt;
        end
    end

    assign period_done = r_pdone;
    assign period_len  = r_per_len;
`else
    assign period_done = 1'b0;
    assign period_len  = '0;
`endif

endmodule

// File: tb/tb_tri_seq_checker.sv
// Self-checking bench for tri_seq_checker: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_tri_seq_checker;

    localparam int MAXV     = 15;
    localparam int SYNC_LEN = 2;
    localparam int ERR_MAX  = 255;
    localparam int PER_MAX  = 63;

    logic       CP;
    logic       CLEAR;
    logic       sample_valid;
    logic [3:0] sample;
    logic       locked, dir_down, peak, valley, err, period_done;
    logic [7:0] err_count;
    logic [5:0] period_len;

    int n_pass  = 0;
    int n_total = 0;

    tri_seq_checker dut (
        .CP           (CP),
        .CLEAR        (CLEAR),
        .sample_valid (sample_valid),
        .sample       (sample),
        .locked       (locked),
        .dir_down     (dir_down),
        .peak         (peak),
        .valley       (valley),
        .err          (err),
        .err_count    (err_count),
        .period_done  (period_done),
        .period_len   (period_len)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    // Model: mode 0 hunting, 1 syncing, 2 locked; directions as signed steps +1/-1.
    int m_mode, m_prev, m_run, m_lastd, m_d, m_errc, m_pc, m_plen;
    bit m_locked, m_dirdn, m_peak, m_valley, m_err, m_seen, m_pdone;

    task automatic model_reset();
        m_mode = 0; m_prev = 0; m_run = 0; m_lastd = 0; m_d = 1; m_errc = 0;
        m_pc = 0; m_plen = 0; m_locked = 0; m_dirdn = 0; m_peak = 0;
        m_valley = 0; m_err = 0; m_seen = 0; m_pdone = 0;
    endtask

    task automatic model_step(input bit v, input int s);
        int d;
        int dd;
        int nxt;
        m_peak = 0; m_valley = 0; m_err = 0; m_pdone = 0;
        if (v) begin
            if (m_mode == 0) begin
                m_run  = 0;
                m_mode = 1;
            end else if (m_mode == 1) begin
                d = s - m_prev;
                if (s <= MAXV && m_prev <= MAXV && (d == 1 || d == -1)) begin
                    m_run   = (m_run > 0 && d == m_lastd) ? m_run + 1 : 1;
                    m_lastd = d;
                    if (m_run >= SYNC_LEN) begin
                        m_mode = 2; m_locked = 1; m_d = d; m_dirdn = (d < 0);
                    end
                end else begin
                    m_run = 0;
                end
            end else begin
                dd  = m_d;
                nxt = m_prev + dd;
                if (nxt < 0 || nxt > MAXV) begin
                    dd  = -dd;
                    nxt = m_prev + dd;
                end
                if (s == nxt) begin
                    m_d = dd; m_dirdn = (dd < 0);
                    m_peak = (s == MAXV); m_valley = (s == 0);
                    if (s == 0) begin
                        if (m_seen) begin
                            m_pdone = 1; m_plen = m_pc;
                        end
                        m_pc = 1; m_seen = 1;
                    end else begin
                        m_pc = (m_pc >= PER_MAX) ? PER_MAX : m_pc + 1;
                    end
                end else begin
                    m_err = 1;
                    m_errc = (m_errc >= ERR_MAX) ? ERR_MAX : m_errc + 1;
                    m_locked = 0; m_dirdn = 0; m_run = 0; m_mode = 1;
                    m_pc = 0; m_seen = 0;
                end
            end
            m_prev = s;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic check_all(input string where);
        chk({where, ".locked"},    32'(locked),    32'(m_locked));
        chk({where, ".dir_down"},  32'(dir_down),  32'(m_dirdn));
        chk({where, ".peak"},      32'(peak),      32'(m_peak));
        chk({where, ".valley"},    32'(valley),    32'(m_valley));
        chk({where, ".err"},       32'(err),       32'(m_err));
        chk({where, ".err_count"}, 32'(err_count), 32'(m_errc));
`ifdef TRI_CHECK_PERIOD_EN
        chk({where, ".period_done"}, 32'(period_done), 32'(m_pdone));
        chk({where, ".period_len"},  32'(period_len),  32'(m_plen));
`else
        chk({where, ".period_done"}, 32'(period_done), 32'd0);
        chk({where, ".period_len"},  32'(period_len),  32'd0);
`endif
    endtask

    // Called at posedge+1; drives inputs, waits one edge, updates model, checks at posedge+1.
    task automatic tick(input string where, input bit v, input int s);
        sample_valid = v;
        sample       = 4'(s);
        @(posedge CP);
        model_step(v, s);
        #1;
        check_all(where);
    endtask

    function automatic int tri_val(input int p);
        int q;
        q = p % (2 * MAXV);
        return (q <= MAXV) ? q : 2 * MAXV - q;
    endfunction

    task automatic run_tri(input string where, input int phase, input int n);
        for (int k = 0; k < n; k++) tick(where, 1'b1, tri_val(phase + k));
    endtask

    initial begin
        int ph;
        int r;
        CLEAR = 1'b1; sample_valid = 1'b0; sample = 4'd0;
        model_reset();
        @(posedge CP); @(posedge CP); #1;
        check_all("reset");
        CLEAR = 1'b0;

        // Scenario 1: clean ramp from 0, peak, turnaround, valley, full period.
        run_tri("t1_ramp", 0, 3);
        chk("t1_lock_after_3", 32'(locked), 32'd1);
        chk("t1_dir_up", 32'(dir_down), 32'd0);
        run_tri("t1_up", 3, 12);
        run_tri("t1_top", 15, 1);
        chk("t1_peak", 32'(peak), 32'd1);
        run_tri("t1_turn", 16, 1);
        chk("t1_dir_down_after_14", 32'(dir_down), 32'd1);
        run_tri("t1_down", 17, 13);
        run_tri("t1_bottom", 30, 1);
        chk("t1_valley", 32'(valley), 32'd1);
        run_tri("t1_second", 31, 29);
        run_tri("t1_valley2", 60, 1);
        chk("t1_err_count", 32'(err_count), 32'd0);
`ifdef TRI_CHECK_PERIOD_EN
        chk("t1_period_done", 32'(period_done), 32'd1);
        chk("t1_period_len", 32'(period_len), 32'd30);
`else
        chk("t1_period_done_off", 32'(period_done), 32'd0);
        chk("t1_period_len_off", 32'(period_len), 32'd0);
`endif

        // Scenario 2: start mid-descent.
        #2 CLEAR = 1'b1; #1 CLEAR = 1'b0;
        model_reset();
        @(posedge CP); #1;
        tick("t2_9", 1'b1, 9);
        tick("t2_8", 1'b1, 8);
        chk("t2_dir_before_lock", 32'(dir_down), 32'd0);
        chk("t2_unlocked", 32'(locked), 32'd0);
        tick("t2_7", 1'b1, 7);
        chk("t2_locked", 32'(locked), 32'd1);
        chk("t2_dir_down", 32'(dir_down), 32'd1);
        tick("t2_6", 1'b1, 6);

        // Scenario 3: skip from 6 to 3, then relock on 2,1.
        tick("t3_err", 1'b1, 3);
        chk("t3_err_pulse", 32'(err), 32'd1);
        chk("t3_err_count", 32'(err_count), 32'd1);
        chk("t3_unlocked", 32'(locked), 32'd0);
        tick("t3_2", 1'b1, 2);
        chk("t3_err_one_cycle", 32'(err), 32'd0);
        tick("t3_1", 1'b1, 1);
        chk("t3_relocked", 32'(locked), 32'd1);
        chk("t3_relock_dir", 32'(dir_down), 32'd1);

        // Scenario 4: invalid cycles with a wrong value on the bus are ignored.
        for (int i = 0; i < 5; i++) tick("t4_idle", 1'b0, 11);
        chk("t4_no_err", 32'(err), 32'd0);
        chk("t4_still_locked", 32'(locked), 32'd1);
        tick("t4_resume", 1'b1, 0);
        chk("t4_resume_valley", 32'(valley), 32'd1);

        // Scenario 5: reach err_count=3, then asynchronous CLEAR mid-cycle.
        tick("t5_e2", 1'b1, 9);
        tick("t5_a", 1'b1, 10);
        tick("t5_b", 1'b1, 11);
        tick("t5_e3", 1'b1, 5);
        tick("t5_c", 1'b1, 6);
        tick("t5_d", 1'b1, 7);
        tick("t5_e", 1'b1, 8);
        chk("t5_count3", 32'(err_count), 32'd3);
        chk("t5_locked_pre", 32'(locked), 32'd1);
        #2 CLEAR = 1'b1;
        #1;
        model_reset();
        check_all("t5_async_clear");
        @(posedge CP); #1;
        CLEAR = 1'b0;

        // Randomized traffic: mostly clean triangle with glitches and idle cycles.
        ph = 7;
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 10)      tick("rnd_idle", 1'b0, int'($urandom_range(0, 15)));
            else if (r < 16) tick("rnd_glitch", 1'b1, int'($urandom_range(0, 15)));
            else begin
                tick("rnd_tri", 1'b1, tri_val(ph));
                ph++;
            end
        end

        // Drive err_count into saturation by repeated lock-then-break.
        for (int i = 0; i < 270; i++) begin
            tick("sat_0", 1'b1, 0);
            tick("sat_1", 1'b1, 1);
            tick("sat_2", 1'b1, 2);
            tick("sat_x", 1'b1, 9);
        end
        chk("sat_err_count", 32'(err_count), 32'd255);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
